traffic_sensor_conditioner: RTL and testbench
=============================================

Name: traffic_sensor_conditioner

Overview:
- Upstream stage of the two-road traffic-light controller.
- Converts raw, asynchronous, bouncy vehicle-detector inputs for road A and road B into clean presence flags T_A / T_B for the light FSM.
- Holds each flag high for a grace period after the vehicle leaves, so a light does not drop to yellow on a momentary gap.
- Generates the slow TICK strobe that paces debounce and hold timing.

Parameters:
TICK_DIV, 50000, CLK cycles per TICK period (>=1)
DEB_TICKS, 4, consecutive TICKs a changed input must persist before it is accepted (>=1)
HOLD_TICKS, 3, TICKs a presence flag stays high after debounced input falls (>=0)
STUCK_TICKS, 60, TICKs of continuous debounced presence before a lane is declared stuck (only with the optional feature)

Ports:
CLK  in  1  system clock
R  in  1  reset. One clock; reset is asynchronous and active-low (R=0 resets).
S_A  in  1  raw detector, road A, asynchronous to CLK
S_B  in  1  raw detector, road B, asynchronous to CLK
T_A  out  1  conditioned presence, road A
T_B  out  1  conditioned presence, road B
TICK  out  1  one-CLK pulse every TICK_DIV cycles
FAULT  out  2  [1]=B stuck, [0]=A stuck (only with SENSOR_STUCK_EN)

Behaviour:
- Reset (R low, asynchronous): T_A, T_B, TICK and FAULT = 0; prescaler = 0; synchronisers and debounced values = 0; lane FSMs in IDLE; all counters = 0. Releasing R mid-operation restarts everything from this state.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. TICK is registered, high for exactly the cycle after the counter equals TICK_DIV-1. With TICK_DIV=1, TICK is constantly high after the first cycle out of reset.
- Synchroniser: a 2-flop chain per lane; sync_x lags S_x by 2 CLK.
- Debounce (per lane, evaluated only on TICK cycles):
  - If sync_x != deb_x, increment dcnt.
  - If sync_x == deb_x, clear dcnt.
  - When the increment would reach DEB_TICKS, toggle deb_x and clear dcnt.
  - A glitch shorter than DEB_TICKS TICKs never changes deb_x.
- Lane FSM (per lane, registered; T_x is high in PRESENT and HOLD):
  - IDLE: deb_x=1 -> PRESENT.
  - PRESENT: deb_x=0 -> HOLD, with hcnt=HOLD_TICKS. If HOLD_TICKS=0, go straight to IDLE.
  - HOLD: deb_x=1 -> PRESENT, which takes priority over expiry. Otherwise, on TICK, decrement hcnt; when hcnt is 1 on that TICK -> IDLE.
- Latency: T_x rises exactly 1 CLK after deb_x rises, and falls HOLD_TICKS TICKs (+1 CLK) after deb_x falls.
- Lanes are fully independent. Simultaneous A and B events are processed in the same cycle with no arbitration; arbitration belongs to the light FSM.

Optional Feature:
SENSOR_STUCK_EN
- Defined:
  - Each lane has a stuck counter. It increments on TICK while deb_x=1 and clears when deb_x=0, saturating at STUCK_TICKS.
  - At saturation, FAULT[x]=1 and T_x is forced to 0 on the next CLK, so the other road is not starved.
  - FAULT[x] clears, and T_x follows normal FSM behaviour again, 1 CLK after deb_x returns to 0.
- Undefined: no FAULT port, no stuck counters, T_x purely from the lane FSM.

Decomposition:
- Shared package traffic_pkg:
  - lane state encoding (IDLE=2'b00, PRESENT=2'b01, HOLD=2'b10);
  - the light-colour bit positions used by the light FSM (GREEN=2, YELLOW=1, RED=0);
  - a clog2 counter-width helper.
- Sub-module sensor_lane (synchroniser, debounce, hold FSM, optional stuck counter), instantiated once for A and once for B. The top level holds the prescaler and the port mapping.

Test Plan:
All tests use TICK_DIV=4, DEB_TICKS=2, HOLD_TICKS=3, STUCK_TICKS=8.
- Reset: hold R=0 with S_A=S_B=1 for 20 CLK -> T_A=T_B=TICK=0. Release R -> TICK pulses first at CLK 4 and then every 4 CLK.
- Clean press: S_A 0->1 held -> T_A rises within 2 sync + 2 TICKs (<=11 CLK). T_B stays 0.
- Glitch reject: S_B=1 for 3 CLK, then 0 -> T_B never asserts; dcnt returns to 0.
- Hold and re-trigger:
  - From T_A=1, drop S_A -> T_A stays high 3 TICKs after deb_A falls, then goes 0.
  - Repeat, but reassert S_A during HOLD -> T_A never drops.
- Async reset mid-HOLD: pull R low -> T_A=0 in the same cycle, without waiting for a CLK edge; lane restarts in IDLE.
- SENSOR_STUCK_EN: S_A held high -> after 8 TICKs at deb_A=1, FAULT=2'b01 and T_A=0. Release S_A -> FAULT=0 once deb_A falls.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: lane state encoding,
// light colour bit positions and a counter-width helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    LANE_IDLE    = 2'b00,
    LANE_PRESENT = 2'b01,
    LANE_HOLD    = 2'b10
  } lane_state_e;

  // Bit positions of the one-hot light colour vector driven by the light FSM.
  localparam int LIGHT_GREEN  = 2;
  localparam int LIGHT_YELLOW = 1;
  localparam int LIGHT_RED    = 0;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int clog2_width(input int max_val);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) <= max_val)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sensor_lane.sv
// One detector lane: 2-flop synchroniser, TICK-paced debounce, presence/hold FSM.
// With SENSOR_STUCK_EN defined, a stuck counter masks a lane that never clears.
//
// state   | meaning
// IDLE    | no vehicle, t_out low
// PRESENT | debounced presence, t_out high
// HOLD    | presence gone, t_out held high for the grace period
module sensor_lane
  import traffic_pkg::*;
#(
`ifdef SENSOR_STUCK_EN
  parameter int STUCK_TICKS = 60,
`endif
  parameter int DEB_TICKS  = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic s_raw,
`ifdef SENSOR_STUCK_EN
  output logic fault,
`endif
  output logic t_out
);

  localparam int DW = clog2_width(DEB_TICKS);
  localparam int HW = clog2_width(HOLD_TICKS);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  lane_state_e state_q, state_d;

  always_comb begin
    sync1_d = s_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    dcnt_d  = dcnt_q;
    if (tick) begin
      if (sync2_q != deb_q) begin
        if (dcnt_q == DEB_LAST) begin
          deb_d  = ~deb_q;
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end else begin
        dcnt_d = '0;
      end
    end
  end

  // A returning vehicle in HOLD wins over an expiring grace period.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      LANE_IDLE: begin
        if (deb_q) state_d = LANE_PRESENT;
      end
      LANE_PRESENT: begin
        if (!deb_q) begin
          if (HOLD_TICKS == 0) begin
            state_d = LANE_IDLE;
          end else begin
            state_d = LANE_HOLD;
            hcnt_d  = HOLD_LOAD;
          end
        end
      end
      LANE_HOLD: begin
        if (deb_q) begin
          state_d = LANE_PRESENT;
        end else if (tick) begin
          if (hcnt_q == HW'(1)) state_d = LANE_IDLE;
          hcnt_d = hcnt_q - HW'(1);
        end
      end
      default: state_d = LANE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      state_q <= LANE_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
    end
  end

`ifdef SENSOR_STUCK_EN
  localparam int SW = clog2_width(STUCK_TICKS);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_TICKS);

  logic [SW-1:0] stuck_q, stuck_d;
  logic fault_q, fault_d;

  always_comb begin
    stuck_d = stuck_q;
    fault_d = deb_q && (stuck_q == STUCK_MAX);
    if (!deb_q) begin
      stuck_d = '0;
    end else if (tick && (stuck_q != STUCK_MAX)) begin
      stuck_d = stuck_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= '0;
      fault_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
  // A stuck lane is masked so the other road is not starved.
  assign t_out = (state_q != LANE_IDLE) && !fault_q;
`else
  assign t_out = (state_q != LANE_IDLE);
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Detector conditioning for roads A and B: TICK prescaler plus two sensor lanes.
// Define SENSOR_STUCK_EN to add per-lane stuck detection and the FAULT port.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
`ifdef SENSOR_STUCK_EN
  parameter int STUCK_TICKS = 60,
`endif
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       S_A,
  input  logic       S_B,
  output logic       T_A,
  output logic       T_B,
`ifdef SENSOR_STUCK_EN
  output logic [1:0] FAULT,
`endif
  output logic       TICK
);

  localparam int PW = clog2_width(TICK_DIV - 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic tick_q, tick_d;

  always_comb begin
    tick_d = (pcnt_q == DIV_LAST);
    pcnt_d = tick_d ? '0 : pcnt_q + PW'(1);
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

  sensor_lane #(
`ifdef SENSOR_STUCK_EN
    .STUCK_TICKS(STUCK_TICKS),
`endif
    .DEB_TICKS  (DEB_TICKS),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_lane_a (
    .clk   (CLK),
    .rst_n (R),
    .tick  (tick_q),
    .s_raw (S_A),
`ifdef SENSOR_STUCK_EN
    .fault (FAULT[0]),
`endif
    .t_out (T_A)
  );

  sensor_lane #(
`ifdef SENSOR_STUCK_EN
    .STUCK_TICKS(STUCK_TICKS),
`endif
    .DEB_TICKS  (DEB_TICKS),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_lane_b (
    .clk   (CLK),
    .rst_n (R),
    .tick  (tick_q),
    .s_raw (S_B),
`ifdef SENSOR_STUCK_EN
    .fault (FAULT[1]),
`endif
    .t_out (T_B)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner against a behavioural
// lane model; exercises SENSOR_STUCK_EN when that macro is defined.
module tb_traffic_sensor_conditioner;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam int HT = 3;
  localparam int ST = 8;

  logic CLK = 1'b0;
  logic R, S_A, S_B;
  logic T_A, T_B, TICK;
`ifdef SENSOR_STUCK_EN
  logic [1:0] FAULT;
`endif

  always #5 CLK = ~CLK;

  traffic_sensor_conditioner #(
`ifdef SENSOR_STUCK_EN
    .STUCK_TICKS(ST),
`endif
    .TICK_DIV   (TD),
    .DEB_TICKS  (DB),
    .HOLD_TICKS (HT)
  ) dut (
    .CLK  (CLK),
    .R    (R),
    .S_A  (S_A),
    .S_B  (S_B),
    .T_A  (T_A),
    .T_B  (T_B),
`ifdef SENSOR_STUCK_EN
    .FAULT(FAULT),
`endif
    .TICK (TICK)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: edge count since reset, per-lane pipeline and flags.
  int m_cyc;
  bit m_tick;
  bit m_sy1[2], m_sy2[2], m_deb[2], m_on[2], m_fault[2];
  int m_dcnt[2], m_gap[2], m_st[2];

  task automatic model_reset();
    m_cyc = 0;
    m_tick = 0;
    for (int l = 0; l < 2; l++) begin
      m_sy1[l] = 0; m_sy2[l] = 0; m_deb[l] = 0; m_on[l] = 0; m_fault[l] = 0;
      m_dcnt[l] = 0; m_gap[l] = 0; m_st[l] = 0;
    end
  endtask

  // One rising edge: everything on the right-hand side is the pre-edge value.
  task automatic model_edge();
    bit tk;
    bit s, deb_old;
    tk = m_tick;
    for (int l = 0; l < 2; l++) begin
      s = (l == 0) ? S_A : S_B;
      deb_old = m_deb[l];
      if (tk) begin
        if (m_sy2[l] != deb_old) begin
          if (m_dcnt[l] + 1 == DB) begin
            m_deb[l] = !deb_old;
            m_dcnt[l] = 0;
          end else begin
            m_dcnt[l] = m_dcnt[l] + 1;
          end
        end else begin
          m_dcnt[l] = 0;
        end
      end
      m_sy2[l] = m_sy1[l];
      m_sy1[l] = s;
      // m_gap < 0: vehicle present; > 0: grace TICKs remaining.
      if (deb_old) begin
        m_on[l] = 1;
        m_gap[l] = -1;
      end else if (m_on[l] && m_gap[l] < 0) begin
        if (HT == 0) m_on[l] = 0;
        else m_gap[l] = HT;
      end else if (m_on[l] && tk) begin
        m_gap[l] = m_gap[l] - 1;
        if (m_gap[l] == 0) m_on[l] = 0;
      end
`ifdef SENSOR_STUCK_EN
      m_fault[l] = deb_old && (m_st[l] == ST);
      if (!deb_old) m_st[l] = 0;
      else if (tk && m_st[l] < ST) m_st[l] = m_st[l] + 1;
`endif
    end
    m_tick = ((m_cyc % TD) == TD - 1);
    m_cyc = m_cyc + 1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("T_A", {1'b0, T_A}, {1'b0, m_on[0] && !m_fault[0]});
    check("T_B", {1'b0, T_B}, {1'b0, m_on[1] && !m_fault[1]});
    check("TICK", {1'b0, TICK}, {1'b0, m_tick});
`ifdef SENSOR_STUCK_EN
    check("FAULT", FAULT, {m_fault[1], m_fault[0]});
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    if (R) model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    int n;
    bit ok, dropped;
    int run_a, run_b;

    R = 1'b0; S_A = 1'b1; S_B = 1'b1;
    model_reset();
    repeat (20) step();
    check("reset_T_A", {1'b0, T_A}, 2'b00);
    check("reset_T_B", {1'b0, T_B}, 2'b00);
    check("reset_TICK", {1'b0, TICK}, 2'b00);

    R = 1'b1; S_A = 1'b0; S_B = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      check("tick_phase", {1'b0, TICK}, {1'b0, (c % 4) == 0});
    end

    // Clean press on A.
    S_A = 1'b1;
    n = 0;
    while (!T_A && n < 11) begin
      step();
      n++;
    end
    check("press_latency", {1'b0, T_A}, 2'b01);
    check("press_T_B_quiet", {1'b0, T_B}, 2'b00);
    repeat (8) step();

    // Short glitch on B.
    S_B = 1'b1;
    repeat (3) step();
    S_B = 1'b0;
    dropped = 0;
    repeat (24) begin
      step();
      if (T_B) dropped = 1;
    end
    check("glitch_reject", {1'b0, dropped}, 2'b00);

    // Release A and let the grace period run out.
    S_A = 1'b0;
    repeat (40) step();
    check("hold_expired", {1'b0, T_A}, 2'b00);

    // Re-trigger during HOLD: A must not drop.
    S_A = 1'b1;
    repeat (20) step();
    S_A = 1'b0;
    n = 0;
    while (m_deb[0] && n < 40) begin
      step();
      n++;
    end
    check("wait_deb_fall", {1'b0, !m_deb[0]}, 2'b01);
    S_A = 1'b1;
    dropped = 0;
    repeat (30) begin
      step();
      if (!T_A) dropped = 1;
    end
    check("retrigger_no_drop", {1'b0, dropped}, 2'b00);

    // Asynchronous reset while A is in HOLD.
    S_A = 1'b0;
    n = 0;
    while (!(m_on[0] && m_gap[0] > 0) && n < 40) begin
      step();
      n++;
    end
    ok = m_on[0] && m_gap[0] > 0;
    check("wait_hold", {1'b0, ok}, 2'b01);
    check("hold_T_A_high", {1'b0, T_A}, 2'b01);
    #2;
    R = 1'b0;
    #1;
    check("async_rst_T_A", {1'b0, T_A}, 2'b00);
    check("async_rst_TICK", {1'b0, TICK}, 2'b00);
    model_reset();
    repeat (3) step();
    R = 1'b1;
    repeat (16) step();
    check("after_rst_idle", {1'b0, T_A}, 2'b00);

`ifdef SENSOR_STUCK_EN
    S_A = 1'b1;
    repeat (60) step();
    check("stuck_fault", FAULT, 2'b01);
    check("stuck_T_A_masked", {1'b0, T_A}, 2'b00);
    S_A = 1'b0;
    repeat (30) step();
    check("stuck_cleared", FAULT, 2'b00);
`endif

    // Random run lengths on both lanes.
    run_a = 1; run_b = 1;
    repeat (2000) begin
      run_a--; run_b--;
      if (run_a <= 0) begin
        S_A = ~S_A;
        run_a = $urandom_range(1, 30);
      end
      if (run_b <= 0) begin
        S_B = ~S_B;
        run_b = $urandom_range(1, 30);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
